// File: rtl/light_pattern_gen_pkg.sv
// Shared game definitions for the light pattern generator: FSM encodings,
// LFSR polynomial, default seed and the lit-count ceiling.
package light_pattern_gen_pkg;

   localparam logic [1:0]  ST_FREE      = 2'd0;
   localparam logic [1:0]  ST_BUILD     = 2'd1;
   localparam logic [1:0]  ST_HOLD      = 2'd2;

   localparam logic [15:0] LFSR_MASK    = 16'hB400;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
   localparam int          MAX_LIGHTS   = 4;

   // One step of the 16-bit right-shifting Galois LFSR
   function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
      logic [15:0] nxt;
      nxt = cur >> 1;
      if (cur[0]) begin
         nxt = nxt ^ LFSR_MASK;
      end else begin
         nxt = nxt;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/light_pattern_gen_lfsr16.sv
// Free-running 16-bit Galois LFSR with a parallel load for reseeding.
module lfsr16
   import light_pattern_gen_pkg::*;
#(
   parameter logic [15:0] SEED = DEFAULT_SEED
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] load_value,
   output logic [15:0] value
);

   logic [15:0] lfsr_r;

   // Advance every cycle; a load takes priority over the shift
   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_r <= SEED;
      end else if (load) begin
         lfsr_r <= load_value;
      end else begin
         lfsr_r <= lfsr_step(lfsr_r);
      end
   end

   assign value = lfsr_r;

endmodule

// File: rtl/light_pattern_gen.sv
// Builds a random pattern of select+1 distinct lit bits, one per cycle,
// and freezes it for the game FSM until random_enable is raised again.
module light_pattern_gen
   import light_pattern_gen_pkg::*;
#(
   parameter logic [15:0] SEED = DEFAULT_SEED
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        random_enable,
   input  logic        lights_off,
   input  logic [1:0]  select,
   input  logic        seed_load,
   input  logic [15:0] seed_in,
   output logic [15:0] light_pattern,
   output logic        pattern_ready,
   output logic [2:0]  lit_count
);

   logic [1:0]  state_r,   state_nxt_s;
   logic [15:0] pattern_r, pattern_nxt_s;
   logic [2:0]  count_r,   count_nxt_s;
   logic [2:0]  target_r,  target_nxt_s;
   logic        load_s;
   logic [15:0] load_value_s;
   logic [15:0] lfsr_value_s;

   // One-hot of the first clear bit at or above the LFSR index, wrapping 15->0
   function automatic logic [15:0] pick_bit(input logic [15:0] pat,
                                            input logic [15:0] rnd);
      logic [15:0] hit;
      logic [3:0]  pos;
      logic        found;
      hit   = 16'h0000;
      found = 1'b0;
      for (int k = 0; k < 16; k++) begin
         pos = rnd[3:0] + k[3:0];
         if (!found && !pat[pos]) begin
            hit[pos] = 1'b1;
            found    = 1'b1;
         end else begin
            found    = found;
         end
      end
      return hit;
   endfunction

   // Reseeding is only allowed while free-running; zero would lock the LFSR
   always_comb begin
      load_s       = (seed_load && (state_r == ST_FREE));
      load_value_s = seed_in;
      if (seed_in == 16'h0000) begin
         load_value_s = SEED;
      end else begin
         load_value_s = seed_in;
      end
   end

   lfsr16 #(.SEED(SEED)) u_lfsr (
      .clk        (clk),
      .reset      (reset),
      .load       (load_s),
      .load_value (load_value_s),
      .value      (lfsr_value_s)
   );

   // Pattern FSM next-state: free-run, build one bit per cycle, hold
   always_comb begin
      state_nxt_s   = state_r;
      pattern_nxt_s = pattern_r;
      count_nxt_s   = count_r;
      target_nxt_s  = target_r;
      case (state_r)
         ST_FREE: begin
            pattern_nxt_s = 16'h0000;
            count_nxt_s   = 3'd0;
            if (!random_enable) begin
               target_nxt_s = {1'b0, select} + 3'd1;
               state_nxt_s  = ST_BUILD;
            end else begin
               state_nxt_s  = ST_FREE;
            end
         end
         ST_BUILD: begin
            if (random_enable) begin
               state_nxt_s   = ST_FREE;
               pattern_nxt_s = 16'h0000;
               count_nxt_s   = 3'd0;
            end else begin
               pattern_nxt_s = pattern_r | pick_bit(pattern_r, lfsr_value_s);
               count_nxt_s   = count_r + 3'd1;
               if ((count_r + 3'd1) == target_r) begin
                  state_nxt_s = ST_HOLD;
               end else begin
                  state_nxt_s = ST_BUILD;
               end
            end
         end
         ST_HOLD: begin
            if (random_enable) begin
               state_nxt_s   = ST_FREE;
               pattern_nxt_s = 16'h0000;
               count_nxt_s   = 3'd0;
            end else begin
               state_nxt_s   = ST_HOLD;
            end
         end
         default: begin
            state_nxt_s   = ST_FREE;
            pattern_nxt_s = 16'h0000;
            count_nxt_s   = 3'd0;
         end
      endcase
   end

   // State, pattern, count and latched target registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_FREE;
         pattern_r <= 16'h0000;
         count_r   <= 3'd0;
         target_r  <= 3'd1;
      end else begin
         state_r   <= state_nxt_s;
         pattern_r <= pattern_nxt_s;
         count_r   <= count_nxt_s;
         target_r  <= target_nxt_s;
      end
   end

   // LEDs show the frozen pattern only when not blanked
   always_comb begin
      if ((state_r == ST_HOLD) && !lights_off) begin
         light_pattern = pattern_r;
      end else begin
         light_pattern = 16'h0000;
      end
   end

   assign pattern_ready = (state_r == ST_HOLD);
   assign lit_count     = count_r;

endmodule

// File: tb/tb_light_pattern_gen.sv
// Bench for light_pattern_gen: a behavioural model checked every cycle plus
// directed scenarios with hand-computed values.
module tb_light_pattern_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        random_enable;
   logic        lights_off;
   logic [1:0]  select;
   logic        seed_load;
   logic [15:0] seed_in;
   logic [15:0] light_pattern;
   logic        pattern_ready;
   logic [2:0]  lit_count;

   int checks = 0;
   int errors = 0;
   bit model_on = 1'b0;

   // model: picks still owed, building flag, frozen flag, pattern, lfsr
   int          m_left;
   bit          m_busy;
   bit          m_ready;
   logic [15:0] m_pat;
   logic [15:0] m_lfsr;

   always #5 clk = ~clk;

   light_pattern_gen dut (
      .clk           (clk),
      .reset         (reset),
      .random_enable (random_enable),
      .lights_off    (lights_off),
      .select        (select),
      .seed_load     (seed_load),
      .seed_in       (seed_in),
      .light_pattern (light_pattern),
      .pattern_ready (pattern_ready),
      .lit_count     (lit_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [15:0] f_step(input logic [15:0] v);
      logic [15:0] mask = 16'hB400;
      return (v % 2 == 1) ? ((v / 2) ^ mask) : (v / 2);
   endfunction

   function automatic logic [15:0] f_add(input logic [15:0] pat, input int idx);
      logic [15:0] one = 16'h0001;
      for (int k = 0; k < 16; k++) begin
         int p = (idx + k) % 16;
         if (pat[p] == 1'b0) return pat | (one << p);
      end
      return pat;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_lfsr  <= 16'hACE1;
         m_pat   <= 16'h0000;
         m_busy  <= 1'b0;
         m_ready <= 1'b0;
         m_left  <= 0;
      end else begin
         if (!m_busy && !m_ready && seed_load)
            m_lfsr <= (seed_in == 16'h0000) ? 16'hACE1 : seed_in;
         else
            m_lfsr <= f_step(m_lfsr);
         if (!m_busy && !m_ready) begin
            m_pat <= 16'h0000;
            if (!random_enable) begin
               m_busy <= 1'b1;
               m_left <= int'(select) + 1;
            end
         end else if (random_enable) begin
            m_busy  <= 1'b0;
            m_ready <= 1'b0;
            m_pat   <= 16'h0000;
         end else if (m_busy) begin
            m_pat  <= f_add(m_pat, int'(m_lfsr % 16));
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_busy  <= 1'b0;
               m_ready <= 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         check("model_light_pattern", light_pattern,
               (m_ready && !lights_off) ? m_pat : 16'h0000);
         check("model_pattern_ready", pattern_ready, m_ready);
         check("model_lit_count", lit_count, $countones(m_pat));
         check("model_lfsr", dut.lfsr_value_s, m_lfsr);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      reset = 1'b1; random_enable = 1'b1; lights_off = 1'b0;
      select = 2'b00; seed_load = 1'b0; seed_in = 16'h0000;
      tick();
      model_on = 1'b1;
      tick();
      reset = 1'b0;
      check("reset_lfsr", dut.lfsr_value_s, 16'hACE1);
      check("reset_lp", light_pattern, 16'h0000);
      check("reset_ready", pattern_ready, 1'b0);
      check("reset_count", lit_count, 3'd0);

      // free-run sequence from reset seed
      tick(); check("free_lfsr1", dut.lfsr_value_s, 16'hE270);
      tick(); check("free_lfsr2", dut.lfsr_value_s, 16'h7138);
      tick(); check("free_lfsr3", dut.lfsr_value_s, 16'h389C);
      check("free_lp", light_pattern, 16'h0000);

      // seed 0003, select 01 -> bits 1 then 0
      seed_load = 1'b1; seed_in = 16'h0003;
      tick(); check("seed_lfsr", dut.lfsr_value_s, 16'h0003);
      seed_load = 1'b0; random_enable = 1'b0; select = 2'b01;
      tick(); check("b1_lfsr", dut.lfsr_value_s, 16'hB401);
      check("b1_count", lit_count, 3'd0);
      tick(); check("b2_lfsr", dut.lfsr_value_s, 16'hEE00);
      check("b2_count", lit_count, 3'd1);
      check("b2_ready", pattern_ready, 1'b0);
      tick(); check("hold_lp", light_pattern, 16'h0003);
      check("hold_count", lit_count, 3'd2);
      check("hold_ready", pattern_ready, 1'b1);

      // blanking and ignored inputs in HOLD
      lights_off = 1'b1; #1 check("blank_lp", light_pattern, 16'h0000);
      lights_off = 1'b0; #1 check("unblank_lp", light_pattern, 16'h0003);
      select = 2'b11; seed_load = 1'b1; seed_in = 16'h1234;
      tick(); tick();
      check("hold_sel_lp", light_pattern, 16'h0003);
      check("hold_sel_count", lit_count, 3'd2);
      seed_load = 1'b0;

      // abort during 2nd BUILD cycle
      random_enable = 1'b1; tick();
      check("abort_free_ready", pattern_ready, 1'b0);
      random_enable = 1'b0; select = 2'b11; tick();
      tick(); check("abort_mid_count", lit_count, 3'd1);
      random_enable = 1'b1; tick();
      check("abort_count", lit_count, 3'd0);
      check("abort_ready", pattern_ready, 1'b0);
      tick(); check("abort_ready2", pattern_ready, 1'b0);

      // select change during BUILD ignored: target stays 1
      random_enable = 1'b0; select = 2'b00; tick();
      select = 2'b11; tick();
      check("latch_ready", pattern_ready, 1'b1);
      check("latch_count", lit_count, 3'd1);
      check("latch_pop", $countones(light_pattern), 1);

      // reset in HOLD
      reset = 1'b1; tick(); reset = 1'b0;
      check("rst_hold_lfsr", dut.lfsr_value_s, 16'hACE1);
      check("rst_hold_lp", light_pattern, 16'h0000);
      check("rst_hold_ready", pattern_ready, 1'b0);
      check("rst_hold_count", lit_count, 3'd0);

      // many random-seed builds of four lights
      for (int i = 0; i < 1000; i++) begin
         random_enable = 1'b1; tick();
         seed_load = 1'b1; seed_in = (i == 0) ? 16'h0000 : 16'($urandom);
         tick();
         seed_load = 1'b0; random_enable = 1'b0; select = 2'b11;
         tick();
         n = 0;
         while (!pattern_ready && n < 10) begin
            tick();
            n++;
         end
         check("build_latency", n, 4);
         check("build_popcount", $countones(light_pattern), 4);
         check("build_count", lit_count, 3'd4);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
